// File: rtl/map_rom_arbiter_pkg.sv
// Shared constants for the map ROM arbiter: default map geometry,
// starvation defaults and the grant encoding.
package map_rom_arbiter_pkg;

  localparam int DEF_MAP_WIDTH_BITS  = 4;
  localparam int DEF_MAP_HEIGHT_BITS = 4;
  localparam int DEF_STARVE_LIMIT    = 7;
  localparam int DEF_WAIT_BITS       = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_OVL  = 2'd1,
    GNT_TRC  = 2'd2
  } gnt_e;

endpackage

// File: rtl/map_rom_arbiter_cell_cache.sv
// One-entry overlay cell cache: tag/valid/value registers, hit compare and flush.
module map_cell_cache
  import map_rom_arbiter_pkg::*;
#(
  parameter int MAP_WIDTH_BITS  = DEF_MAP_WIDTH_BITS,
  parameter int MAP_HEIGHT_BITS = DEF_MAP_HEIGHT_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_ovl_en,
  input  logic [MAP_WIDTH_BITS-1:0]  i_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_row,
  input  logic                       i_fill,
  input  logic                       i_fill_val,
  output logic                       o_hit,
  output logic                       o_val
);

  localparam int TAG_BITS = MAP_WIDTH_BITS + MAP_HEIGHT_BITS;

  logic [TAG_BITS-1:0] tag_q;
  logic                valid_q;
  logic                val_q;

  assign o_hit = i_ovl_en & valid_q & ({i_col, i_row} == tag_q);
  assign o_val = val_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (i_fill) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: tag and value carry no reset; valid_q alone decides whether they are trusted.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      tag_q <= {i_col, i_row};
      val_q <= i_fill_val;
    end
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares one map_rom between the pixel-timed overlay and the req/ack wall tracer.
// Define MAP_ARB_OVERLAY_CACHE_EN to add the one-entry overlay cell cache.
module map_rom_arbiter
  import map_rom_arbiter_pkg::*;
#(
  parameter int MAP_WIDTH_BITS  = DEF_MAP_WIDTH_BITS,
  parameter int MAP_HEIGHT_BITS = DEF_MAP_HEIGHT_BITS,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
  parameter int WAIT_BITS       = DEF_WAIT_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_trc_req,
  input  logic [MAP_WIDTH_BITS-1:0]  i_trc_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_trc_row,
  output logic                       o_trc_ack,
  output logic                       o_trc_val,
  input  logic                       i_ovl_en,
  input  logic [MAP_WIDTH_BITS-1:0]  i_ovl_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_ovl_row,
  output logic                       o_ovl_val,
  output logic                       o_ovl_stale,
  output logic [MAP_WIDTH_BITS-1:0]  o_map_col,
  output logic [MAP_HEIGHT_BITS-1:0] o_map_row,
  input  logic                       i_map_val
);

  gnt_e                 gnt_d, gnt_q;
  logic [WAIT_BITS-1:0] wait_d, wait_q;
  logic                 trc_val_q, ovl_val_q, ovl_stale_q;
  logic                 ovl_hit, ovl_need, trc_ok, starve, cache_val;

`ifdef MAP_ARB_OVERLAY_CACHE_EN
  map_cell_cache #(
    .MAP_WIDTH_BITS  (MAP_WIDTH_BITS),
    .MAP_HEIGHT_BITS (MAP_HEIGHT_BITS)
  ) u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (i_flush),
    .i_ovl_en   (i_ovl_en),
    .i_col      (i_ovl_col),
    .i_row      (i_ovl_row),
    .i_fill     (gnt_d == GNT_OVL),
    .i_fill_val (i_map_val),
    .o_hit      (ovl_hit),
    .o_val      (cache_val)
  );
`else
  logic unused_flush;
  assign unused_flush = i_flush;
  assign ovl_hit      = 1'b0;
  assign cache_val    = ovl_val_q;
`endif

  assign ovl_need = i_ovl_en & ~ovl_hit;
  // The ack cycle is never granted, capping the tracer at one lookup per two cycles.
  assign trc_ok   = i_trc_req & ~o_trc_ack;
  assign starve   = (wait_q == WAIT_BITS'(STARVE_LIMIT));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_d  = GNT_NONE;
    wait_d = wait_q;
    if (trc_ok && (starve || !ovl_need)) begin
      gnt_d = GNT_TRC;
    end else if (ovl_need) begin
      gnt_d = GNT_OVL;
    end
    if (!i_trc_req || gnt_d == GNT_TRC) begin
      wait_d = '0;
    end else if (trc_ok && !starve) begin
      wait_d = wait_q + WAIT_BITS'(1);
    end
  end

  assign o_map_col = (gnt_d == GNT_OVL) ? i_ovl_col : i_trc_col;
  assign o_map_row = (gnt_d == GNT_OVL) ? i_ovl_row : i_trc_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= GNT_NONE;
      wait_q      <= '0;
      trc_val_q   <= 1'b0;
      ovl_val_q   <= 1'b0;
      ovl_stale_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      wait_q <= wait_d;
      if (gnt_d == GNT_TRC) begin
        trc_val_q <= i_map_val;
      end
      if (gnt_d == GNT_OVL) begin
        ovl_val_q <= i_map_val;
      end else if (ovl_hit) begin
        ovl_val_q <= cache_val;
      end
      // Stale only when the overlay needed the ROM and lost it to the tracer.
      ovl_stale_q <= (gnt_d == GNT_TRC) && ovl_need;
    end
  end

  assign o_trc_ack   = (gnt_q == GNT_TRC);
  assign o_trc_val   = trc_val_q;
  assign o_ovl_val   = ovl_val_q;
  assign o_ovl_stale = ovl_stale_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Self-checking bench for map_rom_arbiter: behavioural model plus directed vectors.
// Expectations follow MAP_ARB_OVERLAY_CACHE_EN when the bench is built with it.
module tb_map_rom_arbiter;

  localparam int LIMIT = 7;
`ifdef MAP_ARB_OVERLAY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_trc_req = 1'b0;
  logic       i_ovl_en = 1'b0;
  logic [3:0] i_trc_col = '0, i_trc_row = '0, i_ovl_col = '0, i_ovl_row = '0;
  logic       o_trc_ack, o_trc_val, o_ovl_val, o_ovl_stale, i_map_val;
  logic [3:0] o_map_col, o_map_row;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Map contents seen by the arbiter: a simple pattern with both 0s and 1s.
  function automatic logic rom(input logic [3:0] c, input logic [3:0] r);
    return c[0] ^ r[0] ^ r[2];
  endfunction

  assign i_map_val = rom(o_map_col, o_map_row);

  map_rom_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (i_flush),
    .i_trc_req   (i_trc_req),
    .i_trc_col   (i_trc_col),
    .i_trc_row   (i_trc_row),
    .o_trc_ack   (o_trc_ack),
    .o_trc_val   (o_trc_val),
    .i_ovl_en    (i_ovl_en),
    .i_ovl_col   (i_ovl_col),
    .i_ovl_row   (i_ovl_row),
    .o_ovl_val   (o_ovl_val),
    .o_ovl_stale (o_ovl_stale),
    .o_map_col   (o_map_col),
    .o_map_row   (o_map_row),
    .i_map_val   (i_map_val)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid = 1'b0;
  logic [3:0] m_tcol = '0, m_trow = '0;
  logic       m_ovl_val = 1'b0, m_stale = 1'b0, m_ack = 1'b0, m_trc_val = 1'b0;
  int         m_wait = 0;

  // Who owns the ROM this cycle: 0 nobody, 1 overlay, 2 tracer.
  function automatic int pick(output bit need);
    bit hit;
    hit  = CACHE_EN && i_ovl_en && m_valid && i_ovl_col == m_tcol && i_ovl_row == m_trow;
    need = i_ovl_en && !hit;
    if (i_trc_req && !m_ack && (m_wait >= LIMIT || !need)) return 2;
    if (need) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int w;
    bit need;
    if (!reset_n) begin
      m_valid <= 1'b0; m_ovl_val <= 1'b0; m_stale <= 1'b0;
      m_ack   <= 1'b0; m_trc_val <= 1'b0; m_wait  <= 0;
    end else begin
      w = pick(need);
      m_ack   <= (w == 2);
      m_stale <= (w == 2) && need;
      if (w == 2) m_trc_val <= rom(i_trc_col, i_trc_row);
      // Overlay always shows the true cell of its address unless it was starved.
      if (i_ovl_en && (w == 1 || !need)) m_ovl_val <= rom(i_ovl_col, i_ovl_row);
      if (w == 2 || !i_trc_req) m_wait <= 0;
      else if (!m_ack)          m_wait <= (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      if (CACHE_EN) begin
        if (w == 1) begin
          m_tcol <= i_ovl_col;
          m_trow <= i_ovl_row;
        end
        m_valid <= i_flush ? 1'b0 : ((w == 1) ? 1'b1 : m_valid);
      end
    end
  end

  always @(negedge clk) begin
    int w;
    bit need;
    w = pick(need);
    check("trc_ack",   o_trc_ack,   m_ack);
    check("trc_val",   o_trc_val,   m_trc_val);
    check("ovl_val",   o_ovl_val,   m_ovl_val);
    check("ovl_stale", o_ovl_stale, m_stale);
    check("map_col",   o_map_col,   (w == 1) ? i_ovl_col : i_trc_col);
    check("map_row",   o_map_row,   (w == 1) ? i_ovl_row : i_trc_row);
  end

  // Tracer protocol: address must stay put while a request waits for its ack.
  logic       p_req = 1'b0;
  logic [3:0] p_col = '0, p_row = '0;
  always @(posedge clk) begin
    if (reset_n && p_req && i_trc_req && !o_trc_ack)
      assert (i_trc_col == p_col && i_trc_row == p_row)
        else $error("tracer address changed while request pending");
    p_req <= i_trc_req;
    p_col <= i_trc_col;
    p_row <= i_trc_row;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (o_trc_ack) return;
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, ack_at, stale_cnt;

    // Reset held with a tracer request pending.
    i_trc_req = 1'b1; i_trc_col = 4'd1; i_trc_row = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",   o_trc_ack,   0);
    check("rst_trc",   o_trc_val,   0);
    check("rst_ovl",   o_ovl_val,   0);
    check("rst_stale", o_ovl_stale, 0);
    reset_n = 1'b1;
    wait_ack(n);
    check("rst_ack_lat", n, 1);
    check("rst_ack_val", o_trc_val, 1);
    i_trc_req = 1'b0;
    tick();

    // Tracer alone, then back-to-back requests.
    i_trc_req = 1'b1; i_trc_col = 4'd3; i_trc_row = 4'd5;
    #1;
    check("trc_map_col", o_map_col, 3);
    check("trc_map_row", o_map_row, 5);
    wait_ack(n);
    check("trc_lat", n, 1);
    check("trc_val_3_5", o_trc_val, 1);
    for (int k = 0; k < 3; k++) begin
      i_trc_col = 4'(6 + k); i_trc_row = 4'(2 * k);
      wait_ack(n);
      check("b2b_lat", n, 2);
      check("b2b_val", o_trc_val, rom(4'(6 + k), 4'(2 * k)));
    end
    i_trc_req = 1'b0;
    tick();

    // Overlay parked on one cell while the tracer asks.
    i_ovl_en = 1'b1; i_ovl_col = 4'd2; i_ovl_row = 4'd3;
    i_trc_req = 1'b1; i_trc_col = 4'd7; i_trc_row = 4'd1;
    ack_at = 0; stale_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (o_ovl_stale) stale_cnt++;
      if (o_trc_ack && ack_at == 0) begin
        ack_at = c;
        i_trc_req = 1'b0;
      end
    end
    check("hit_ack_at", ack_at, CACHE_EN ? 2 : 8);
    check("hit_stale_cnt", stale_cnt, CACHE_EN ? 0 : 1);
    check("hit_ovl_val", o_ovl_val, 1);

    // Overlay moving every cycle: tracer only gets in by starvation.
    i_trc_req = 1'b1; i_trc_col = 4'd5; i_trc_row = 4'd0;
    i_ovl_col = 4'd0; i_ovl_row = 4'd9;
    ack_at = 0; stale_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (o_ovl_stale) stale_cnt++;
      if (o_trc_ack && ack_at == 0) begin
        ack_at = c;
        check("starve_stale_at_ack", o_ovl_stale, 1);
        i_trc_req = 1'b0;
      end
      i_ovl_col = 4'(c);
    end
    check("starve_ack_at", ack_at, 8);
    check("starve_stale_cnt", stale_cnt, 1);
    check("starve_trc_val", o_trc_val, 1);

    // Flush while the overlay sits on a cached cell.
    i_trc_col = 4'd10; i_trc_row = 4'd11;
    i_ovl_col = 4'd4;  i_ovl_row = 4'd6;
    repeat (3) tick();
    i_flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_col", o_map_col, CACHE_EN ? 10 : 4);
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    check("after_flush_miss_col", o_map_col, 4);
    tick();
    @(negedge clk);
    check("hits_resume_col", o_map_col, CACHE_EN ? 10 : 4);

    // Flush on the same edge as an overlay fill: value updates, tag stays invalid.
    tick();
    i_ovl_col = 4'd5; i_ovl_row = 4'd6; i_flush = 1'b1;
    @(negedge clk);
    check("flush_fill_col", o_map_col, 5);
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_fill_val", o_ovl_val, 0);
    check("flush_fill_miss_col", o_map_col, 5);
    tick();
    @(negedge clk);
    check("flush_fill_hit_col", o_map_col, CACHE_EN ? 10 : 5);

    // Reset in the ack cycle drops the ack; held request is served again.
    tick();
    i_ovl_en = 1'b0; i_trc_req = 1'b1; i_trc_col = 4'd5; i_trc_row = 4'd0;
    wait_ack(n);
    check("mid_lat", n, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", o_trc_ack, 0);
    check("mid_rst_val", o_trc_val, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(n);
    check("rearb_lat", n, 1);
    check("rearb_val", o_trc_val, 1);
    i_trc_req = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
